// File: rtl/spi_slave_fsm_if.sv
// SPI slave bus bundle: serial pins plus the parallel command/read-data
// handshake towards the single-port RAM.
interface spi_slave_fsm_if #(
    parameter int DATA_W = 8
);
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    // The SPI slave block drives MISO and the RAM-facing command word
    modport slave (
        input  SS_n,
        input  MOSI,
        input  tx_data,
        input  tx_valid,
        output MISO,
        output rx_data,
        output rx_valid
    );

    // The SPI master and the RAM side together drive everything the slave samples
    modport master (
        output SS_n,
        output MOSI,
        output tx_data,
        output tx_valid,
        input  MISO,
        input  rx_data,
        input  rx_valid
    );
endinterface

// File: rtl/spi_slave_fsm.sv
// SPI slave front end for the single-port RAM (mode 0 equivalent).
// Deserialises {cmd[1:0], payload} frames from MOSI into rx_data/rx_valid and,
// after a read-data command, serialises the RAM byte back out on MISO.
module spi_slave_fsm #(
    parameter int DATA_W = 8
) (
    input logic           clk,
    input logic           rstn,
    spi_slave_fsm_if.slave bus
);

    localparam int FW    = DATA_W + 2;
    localparam int CNT_W = $clog2(FW + 2);
    localparam int TXC_W = $clog2(DATA_W + 1);

    // bit_cnt == CNT_LAST: all frame bits captured; CNT_DONE: rx_valid issued
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FW);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FW + 1);
    // tx_cnt counts read-data bits already driven; TX_END means all sent
    localparam logic [TXC_W-1:0] TX_LAST  = TXC_W'(DATA_W - 1);
    localparam logic [TXC_W-1:0] TX_END   = TXC_W'(DATA_W);
    localparam logic [TXC_W-1:0] TX_ZERO  = '0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [CNT_W-1:0]  bit_cnt;
    logic [TXC_W-1:0]  tx_cnt;
    logic [FW-1:0]     rx_sh;
    logic [DATA_W-1:0] tx_sh;
    logic              rd_addr_seen;

    logic              in_frame;
    logic              shift_en;
    logic              frame_done;
    logic              tx_load;
    logic              tx_shift;
    logic              rd_seen_set;
    logic              rd_seen_clr;
    logic              miso_nxt;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; SS_n high aborts from any state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!bus.SS_n) begin
                    state_nxt = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (!bus.MOSI) begin
                    state_nxt = WRITE;
                end else if (rd_addr_seen) begin
                    state_nxt = READ_DATA;
                end else begin
                    state_nxt = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                state_nxt = state;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (bus.SS_n) begin
            state_nxt = IDLE;
        end
    end

    // Per-cycle control strobes derived from state and counters
    always_comb begin
        in_frame    = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
        shift_en    = 1'b0;
        frame_done  = 1'b0;
        tx_load     = 1'b0;
        tx_shift    = 1'b0;
        rd_seen_set = 1'b0;
        rd_seen_clr = 1'b0;
        miso_nxt    = 1'b0;
        if (!bus.SS_n) begin
            // CHK_CMD captures the first frame bit, the data states the rest
            shift_en   = (state == CHK_CMD) || (in_frame && (bit_cnt < CNT_LAST));
            frame_done = in_frame && (bit_cnt == CNT_LAST);
            // tx_valid is only honoured once rx_valid has been issued
            tx_load    = (state == READ_DATA) && (bit_cnt == CNT_DONE) &&
                         (tx_cnt == TX_ZERO) && bus.tx_valid;
            tx_shift   = (state == READ_DATA) && (tx_cnt != TX_ZERO) && (tx_cnt != TX_END);
        end
        rd_seen_set = frame_done && (state == READ_ADD);
        rd_seen_clr = tx_shift && (tx_cnt == TX_LAST);
        if (tx_load) begin
            miso_nxt = bus.tx_data[DATA_W-1];
        end else if (tx_shift) begin
            miso_nxt = tx_sh[DATA_W-1];
        end
    end

    // Receive side: bit counter, MOSI shift register and the command word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt      <= '0;
            rx_sh        <= '0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
        end else begin
            bus.rx_valid <= frame_done;
            if (bus.SS_n) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end else if (frame_done) begin
                bit_cnt <= CNT_DONE;
            end
            if (shift_en) begin
                rx_sh <= {rx_sh[FW-2:0], bus.MOSI};
            end
            if (frame_done) begin
                bus.rx_data <= rx_sh;
            end
        end
    end

    // Transmit side: latch the RAM byte and shift it out MSB first on MISO
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_cnt   <= '0;
            tx_sh    <= '0;
            bus.MISO <= 1'b0;
        end else begin
            bus.MISO <= miso_nxt;
            if (bus.SS_n) begin
                tx_cnt <= '0;
            end else if (tx_load) begin
                tx_cnt <= TXC_W'(1);
                tx_sh  <= {bus.tx_data[DATA_W-2:0], 1'b0};
            end else if (tx_shift) begin
                tx_cnt <= tx_cnt + 1'b1;
                tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Read-address flag: set by a completed rd-addr frame, cleared after the read byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr_seen <= 1'b0;
        end else if (rd_seen_set) begin
            rd_addr_seen <= 1'b1;
        end else if (rd_seen_clr) begin
            rd_addr_seen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm: reset, write/read frames, read-data
// serialisation, aborted frames and ignored tx_valid.
module tb_spi_slave_fsm;

    logic clk;
    logic rstn;
    int   total;
    int   passed;
    logic miso_or;

    spi_slave_fsm_if #(.DATA_W(8)) bus ();

    spi_slave_fsm #(.DATA_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, observed running required done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // advance one clock; sample and drive 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        miso_or = miso_or | bus.MISO;
    endtask

    // SS_n low (edge 0), then 10 frame bits MSB first (edges 1..10)
    task automatic frame(input logic [9:0] f);
        bus.SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = f[i];
            tick();
        end
        bus.MOSI = 1'b0;
    endtask

    // full frame plus rx_valid/rx_data checks at edges 10, 11 and 12
    task automatic frame_check(input string tag, input logic [9:0] f);
        frame(f);
        chk({tag, "_vld_e10"}, 32'(bus.rx_valid), 32'd0);
        tick();
        chk({tag, "_vld_e11"}, 32'(bus.rx_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.rx_data), 32'(f));
        tick();
        chk({tag, "_vld_e12"}, 32'(bus.rx_valid), 32'd0);
    endtask

    task automatic release_ss(input string tag);
        bus.SS_n = 1'b1;
        tick();
        chk({tag, "_idle"}, 32'(dut.state), 32'd0);
        chk({tag, "_miso_idle"}, 32'(bus.MISO), 32'd0);
    endtask

    initial begin
        logic [7:0] rd_byte;
        logic       vld_seen;
        total       = 0;
        passed      = 0;
        miso_or     = 1'b0;
        rstn        = 1'b0;
        bus.SS_n    = 1'b1;
        bus.MOSI    = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b0;
        tick();
        tick();
        chk("rst_miso", 32'(bus.MISO), 32'd0);
        chk("rst_vld", 32'(bus.rx_valid), 32'd0);
        chk("rst_data", 32'(bus.rx_data), 32'd0);
        chk("rst_state", 32'(dut.state), 32'd0);
        rstn = 1'b1;
        tick();

        // 1: set rd_addr_seen, then reset in the middle of the next frame
        frame_check("t1_ra", 10'h203);
        chk("t1_seen_set", 32'(dut.rd_addr_seen), 32'd1);
        release_ss("t1_ra");
        bus.SS_n = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.MOSI = 1'b1;
            tick();
        end
        rstn = 1'b0;
        #1;
        chk("t1_mid_state", 32'(dut.state), 32'd0);
        chk("t1_mid_miso", 32'(bus.MISO), 32'd0);
        chk("t1_mid_vld", 32'(bus.rx_valid), 32'd0);
        chk("t1_mid_data", 32'(bus.rx_data), 32'd0);
        chk("t1_mid_seen", 32'(dut.rd_addr_seen), 32'd0);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // 2: write-address frame
        miso_or = 1'b0;
        frame_check("t2", 10'h0A5);
        release_ss("t2");
        chk("t2_miso_quiet", 32'(miso_or), 32'd0);

        // 3: write-data frame leaves rd_addr_seen alone
        frame_check("t3", 10'h1F0);
        chk("t3_seen", 32'(dut.rd_addr_seen), 32'd0);
        release_ss("t3");

        // 4: read address, then read data with MISO serialisation of C3
        frame_check("t4_ra", 10'h203);
        chk("t4_seen", 32'(dut.rd_addr_seen), 32'd1);
        chk("t4_ra_state", 32'(dut.state), 32'd3);
        release_ss("t4_ra");
        frame_check("t4_rd", 10'h35A);
        chk("t4_rd_state", 32'(dut.state), 32'd4);
        chk("t4_rd_cmd", 32'(bus.rx_data[9:8]), 32'd3);
        chk("t4_miso_wait", 32'(bus.MISO), 32'd0);
        bus.tx_data  = 8'hC3;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        rd_byte = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            chk($sformatf("t4_miso_b%0d", i), 32'(bus.MISO), 32'(rd_byte[i]));
            if (i > 0) tick();
        end
        chk("t4_seen_clr", 32'(dut.rd_addr_seen), 32'd0);
        tick();
        chk("t4_miso_after", 32'(bus.MISO), 32'd0);
        release_ss("t4_rd");

        // 5: abort after 5 bits, then a normal frame
        bus.SS_n = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.MOSI = (i % 2 == 0);
            tick();
        end
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        tick();
        chk("t5_abort_idle", 32'(dut.state), 32'd0);
        vld_seen = bus.rx_valid;
        for (int i = 0; i < 6; i++) begin
            tick();
            vld_seen = vld_seen | bus.rx_valid;
        end
        chk("t5_abort_novld", 32'(vld_seen), 32'd0);
        chk("t5_abort_seen", 32'(dut.rd_addr_seen), 32'd0);
        frame_check("t5", 10'h001);
        release_ss("t5");

        // 6: tx_valid held through a WRITE frame has no effect
        miso_or      = 1'b0;
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        frame_check("t6", 10'h055);
        tick();
        tick();
        chk("t6_state", 32'(dut.state), 32'd2);
        chk("t6_miso_quiet", 32'(miso_or), 32'd0);
        bus.tx_valid = 1'b0;
        release_ss("t6");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
